// File: rtl/lcd_bus_driver.sv
`timescale 1ns/1ps
// HD44780-style parallel LCD write driver: one byte per request with SETUP/ENABLE/HOLD/EXEC timing.
// Define LCD_INIT_EN to add a power-up INIT sequence (wait, then 38/0C/06/01) before accepting requests.
module lcd_bus_driver #(
    parameter int T_SETUP   = 2,
    parameter int T_EN      = 12,
    parameter int T_HOLD    = 2,
    parameter int T_EXEC    = 1000,
    parameter int T_CLEAR   = 40000,
    parameter int T_POWERUP = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic       dr,
    input  logic [7:0] dbi,
    input  logic [7:0] direc,
    output logic       ack,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db
);

    // A timed state lasts (load + 1) cycles; a zero parameter still gets one cycle.
    localparam logic [15:0] L_SETUP   = (T_SETUP   <= 1) ? 16'd0 : 16'(T_SETUP   - 1);
    localparam logic [15:0] L_EN      = (T_EN      <= 1) ? 16'd0 : 16'(T_EN      - 1);
    localparam logic [15:0] L_HOLD    = (T_HOLD    <= 1) ? 16'd0 : 16'(T_HOLD    - 1);
    localparam logic [15:0] L_EXEC    = (T_EXEC    <= 1) ? 16'd0 : 16'(T_EXEC    - 1);
    localparam logic [15:0] L_CLEAR   = (T_CLEAR   <= 1) ? 16'd0 : 16'(T_CLEAR   - 1);
    localparam logic [15:0] L_POWERUP = (T_POWERUP <= 1) ? 16'd0 : 16'(T_POWERUP - 1);

`ifdef LCD_INIT_EN
    typedef enum logic [2:0] {INIT, IDLE, SETUP, ENABLE, HOLD, EXEC} state_t;
    localparam state_t RESET_STATE = INIT;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    logic       init_run_q, init_run_d;
    logic       pu_armed_q, pu_armed_d;
    logic [1:0] step_q, step_d;
`else
    typedef enum logic [2:0] {IDLE, SETUP, ENABLE, HOLD, EXEC} state_t;
    localparam state_t RESET_STATE = IDLE;

    logic unused_powerup;
    assign unused_powerup = ^L_POWERUP;
`endif

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ack_d, e_d, rs_d;
    logic [7:0]  db_d;
    logic        is_clear;

    assign is_clear = !lcd_rs && (lcd_db == 8'h01 || lcd_db == 8'h02);
    assign busy     = (state_q != IDLE);
    assign lcd_rw   = 1'b0;

    always_comb begin
        // NOTE: every signal gets a default here so no path through the case infers a latch.
        state_d = state_q;
        cnt_d   = (cnt_q != 16'd0) ? cnt_q - 16'd1 : 16'd0;
        ack_d   = 1'b0;
        e_d     = lcd_e;
        rs_d    = lcd_rs;
        db_d    = lcd_db;
`ifdef LCD_INIT_EN
        init_run_d = init_run_q;
        pu_armed_d = pu_armed_q;
        step_d     = step_q;
`endif
        unique case (state_q)
`ifdef LCD_INIT_EN
            INIT: begin
                if (!pu_armed_q) begin
                    pu_armed_d = 1'b1;
                    cnt_d      = L_POWERUP;
                end else if (cnt_q == 16'd0) begin
                    rs_d    = 1'b0;
                    db_d    = init_cmd(step_q);
                    state_d = SETUP;
                    cnt_d   = L_SETUP;
                end
            end
`endif
            IDLE: begin
                if (dr || wr) begin
                    ack_d   = 1'b1;
                    rs_d    = !dr;
                    db_d    = dr ? direc : dbi;
                    state_d = SETUP;
                    cnt_d   = L_SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == 16'd0) begin
                    state_d = ENABLE;
                    cnt_d   = L_EN;
                    e_d     = 1'b1;
                end
            end
            ENABLE: begin
                if (cnt_q == 16'd0) begin
                    state_d = HOLD;
                    cnt_d   = L_HOLD;
                    e_d     = 1'b0;
                end
            end
            HOLD: begin
                if (cnt_q == 16'd0) begin
                    state_d = EXEC;
                    cnt_d   = is_clear ? L_CLEAR : L_EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 16'd0) begin
                    state_d = IDLE;
`ifdef LCD_INIT_EN
                    if (init_run_q && step_q != 2'd3) begin
                        step_d  = step_q + 2'd1;
                        rs_d    = 1'b0;
                        db_d    = init_cmd(step_q + 2'd1);
                        state_d = SETUP;
                        cnt_d   = L_SETUP;
                    end else begin
                        init_run_d = 1'b0;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_STATE;
            cnt_q   <= 16'd0;
            ack     <= 1'b0;
            lcd_e   <= 1'b0;
            lcd_rs  <= 1'b0;
            lcd_db  <= 8'h00;
`ifdef LCD_INIT_EN
            init_run_q <= 1'b1;
            pu_armed_q <= 1'b0;
            step_q     <= 2'd0;
`endif
        end else begin
            // NOTE: non-blocking so every register updates from the same pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack     <= ack_d;
            lcd_e   <= e_d;
            lcd_rs  <= rs_d;
            lcd_db  <= db_d;
`ifdef LCD_INIT_EN
            init_run_q <= init_run_d;
            pu_armed_q <= pu_armed_d;
            step_q     <= step_d;
`endif
        end
    end

endmodule

// File: tb/tb_lcd_bus_driver.sv
`timescale 1ns/1ps
// Self-checking bench for lcd_bus_driver (default build): expected transfers are queued when
// a request is driven and compared when the matching E strobe and busy period appear.
module tb_lcd_bus_driver;

    localparam int T_SETUP = 2;
    localparam int T_EN    = 12;
    localparam int T_HOLD  = 2;
    localparam int T_EXEC  = 1000;
    localparam int T_CLEAR = 40000;
    localparam int PERIOD  = 1 + T_SETUP + T_EN + T_HOLD + T_EXEC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr = 1'b0, dr = 1'b0;
    logic [7:0] dbi = 8'h00, direc = 8'h00;
    logic       ack, busy, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_db;

    always #5 clk = ~clk;

    lcd_bus_driver #(
        .T_SETUP(T_SETUP), .T_EN(T_EN), .T_HOLD(T_HOLD),
        .T_EXEC(T_EXEC), .T_CLEAR(T_CLEAR), .T_POWERUP(50000)
    ) dut (
        .clk(clk), .rst(rst), .wr(wr), .dr(dr), .dbi(dbi), .direc(direc),
        .ack(ack), .busy(busy), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_e(lcd_e), .lcd_db(lcd_db)
    );

    typedef struct {
        logic       rs;
        logic [7:0] db;
        int         exec;
    } xfer_t;

    xfer_t exp_q[$];
    int    n_checks  = 0;
    int    n_pass    = 0;
    int    ack_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Output monitor: sampled on the falling edge, away from the active edge.
    xfer_t cur;
    logic  cur_valid = 1'b0;
    logic  e_prev = 1'b0, ack_prev = 1'b0;
    int    e_cnt = 0, busy_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            cur_valid = 1'b0;
            e_prev    = 1'b0;
            ack_prev  = 1'b0;
            e_cnt     = 0;
            busy_cnt  = 0;
        end else begin
            if (ack) begin
                ack_total++;
                check("ack_single_cycle", ack_prev, 1'b0);
            end
            if (lcd_e && !e_prev) begin
                check("strobe_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    cur       = exp_q.pop_front();
                    cur_valid = 1'b1;
                    check("rs_at_strobe", lcd_rs, cur.rs);
                    check("db_at_strobe", lcd_db, cur.db);
                    check("rw_low", lcd_rw, 1'b0);
                end
                e_cnt = 0;
            end
            if (lcd_e) e_cnt++;
            if (!lcd_e && e_prev && cur_valid) begin
                check("e_width", e_cnt, T_EN);
                check("db_held_after_e", lcd_db, cur.db);
            end
            if (busy) begin
                busy_cnt++;
            end else if (busy_cnt != 0) begin
                if (cur_valid) begin
                    check("busy_len", busy_cnt, T_SETUP + T_EN + T_HOLD + cur.exec);
                    check("rs_retained", lcd_rs, cur.rs);
                    check("db_retained", lcd_db, cur.db);
                end
                cur_valid = 1'b0;
                busy_cnt  = 0;
            end
            e_prev   = lcd_e;
            ack_prev = ack;
        end
    end

    // Counts edges until ack is seen (sampled 1 ns after each edge).
    task automatic wait_ack(output int lat);
        lat = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            @(posedge clk); #1;
            lat++;
            if (ack) break;
        end
        check("ack_seen", ack, 1'b1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < T_CLEAR + 2 * PERIOD; i++) begin
            @(posedge clk); #1;
            if (!busy) break;
        end
        check("idle_reached", busy, 1'b0);
    endtask

    task automatic send(input logic is_cmd, input logic [7:0] b, input int exec_len, output int lat);
        @(posedge clk); #1;
        if (is_cmd) begin dr = 1'b1; direc = b; end
        else        begin wr = 1'b1; dbi   = b; end
        exp_q.push_back('{rs: !is_cmd, db: b, exec: exec_len});
        wait_ack(lat);
        dr = 1'b0;
        wr = 1'b0;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int acks_before;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", ack, 1'b0);
        check("rst_e", lcd_e, 1'b0);
        check("rst_rs", lcd_rs, 1'b0);
        check("rst_db", lcd_db, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_rw", lcd_rw, 1'b0);
        rst = 1'b0;

        // Single command write: ack one edge after the request
        send(1'b1, 8'h86, T_EXEC, lat);
        check("single_ack_latency", lat, 1);
        check("single_busy_on_ack", busy, 1'b1);
        wait_idle();

        // Clear command gets the long exec time, then a plain character
        send(1'b1, 8'h01, T_CLEAR, lat);
        wait_idle();
        send(1'b0, 8'h48, T_EXEC, lat);
        wait_idle();

        // Collision: dr wins, wr stays pending
        acks_before = ack_total;
        @(posedge clk); #1;
        wr = 1'b1; dbi = 8'h6F;
        dr = 1'b1; direc = 8'hC4;
        exp_q.push_back('{rs: 1'b0, db: 8'hC4, exec: T_EXEC});
        exp_q.push_back('{rs: 1'b1, db: 8'h6F, exec: T_EXEC});
        wait_ack(lat);
        check("collision_first_latency", lat, 1);
        dr = 1'b0;
        wait_ack(lat);
        check("collision_second_period", lat, PERIOD);
        wr = 1'b0;
        wait_idle();
        repeat (5) @(posedge clk);
        check("collision_ack_count", ack_total - acks_before, 2);

        // Held wr: character bytes 01/02 with RS=1 must not get the clear timing
        @(posedge clk); #1;
        wr = 1'b1; dbi = 8'h01;
        exp_q.push_back('{rs: 1'b1, db: 8'h01, exec: T_EXEC});
        wait_ack(lat);
        dbi = 8'h02;
        exp_q.push_back('{rs: 1'b1, db: 8'h02, exec: T_EXEC});
        wait_ack(lat);
        check("held_period_1", lat, PERIOD);
        dbi = 8'h41;
        exp_q.push_back('{rs: 1'b1, db: 8'h41, exec: T_EXEC});
        wait_ack(lat);
        check("held_period_2", lat, PERIOD);
        wr = 1'b0;
        wait_idle();

        // Reset during ENABLE abandons the transfer
        send(1'b1, 8'h80, T_EXEC, lat);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (lcd_e) break;
        end
        check("mid_e_rose", lcd_e, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        acks_before = ack_total;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_e", lcd_e, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ack", ack, 1'b0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_rst_no_ack", ack_total - acks_before, 0);
        send(1'b0, 8'h5A, T_EXEC, lat);
        check("after_rst_latency", lat, 1);
        wait_idle();
        repeat (5) @(posedge clk);

        check("queue_empty", exp_q.size(), 0);
        check("total_acks", ack_total, 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
